// File: rtl/ir_nec_pkg.sv
// Shared definitions for the NEC infrared receiver: FSM state encoding,
// pulse-width windows (in 10 us ticks), counter width and frame length.
package ir_nec_pkg;

   localparam int CNT_W      = 11;
   localparam int FRAME_BITS = 32;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Inclusive acceptance windows, in timing ticks
   localparam int LM_MIN = 720;   // leader mark
   localparam int LM_MAX = 1080;
   localparam int LS_MIN = 360;   // leader space
   localparam int LS_MAX = 540;
   localparam int RS_MIN = 180;   // repeat-frame space
   localparam int RS_MAX = 270;
   localparam int BM_MIN = 40;    // bit / stop / repeat mark
   localparam int BM_MAX = 72;
   localparam int S0_MIN = 40;    // space encoding a 0
   localparam int S0_MAX = 72;
   localparam int S1_MIN = 135;   // space encoding a 1
   localparam int S1_MAX = 203;

   typedef enum logic [3:0] {
      IDLE,
      LEAD_MARK,
      LEAD_SPACE,
      BIT_MARK,
      BIT_SPACE,
      CHECK,
      STOP,
      RPT_MARK,
      ERR
   } state_t;

   // True when a measured duration falls inside [lo, hi]
   function automatic logic in_win(input logic [CNT_W-1:0] dur,
                                   input int lo, input int hi);
      return (int'(dur) >= lo) && (int'(dur) <= hi);
   endfunction

endpackage

// File: rtl/ir_line_filter.sv
// Line conditioning for the IR input: 2-FF synchronizer, a FILT_LEN-sample
// agreement filter, and single-cycle rise/fall pulses on the filtered level.
// The line idles high, so all stages reset to 1 to avoid a false edge.
module ir_line_filter
   import ir_nec_pkg::*;
#(
   parameter int FILT_LEN = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_ir,
   output logic o_rise,
   output logic o_fall
);

   localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

   logic           r_sync1;
   logic           r_sync2;
   logic           r_filt;
   logic           r_filt_d;
   logic [FCW-1:0] r_cnt;

   // Bring the asynchronous receiver output into the clk domain
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments make both flops sample together, forming a real 2-stage chain.
      if (reset) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= i_ir;
         r_sync2 <= r_sync1;
      end
   end

   // Accept a new level only after FILT_LEN consecutive disagreeing samples
   always_ff @(posedge clk) begin
      if (reset) begin
         r_filt   <= 1'b1;
         r_filt_d <= 1'b1;
         r_cnt    <= '0;
      end else begin
         r_filt_d <= r_filt;
         if (r_sync2 == r_filt) begin
            r_cnt <= '0;
         end else if (r_cnt == FCW'(FILT_LEN - 1)) begin
            r_filt <= r_sync2;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + FCW'(1);
         end
      end
   end

   assign o_rise = r_filt & ~r_filt_d;
   assign o_fall = ~r_filt & r_filt_d;

endmodule

// File: rtl/ir_nec_receiver.sv
// NEC infrared frame decoder. Measures mark/space widths in 10 us ticks,
// assembles the 32-bit frame LSB-first, verifies cmd against its inverse and
// hands {addr, cmd} to software with a valid pulse and a sticky interrupt.
// Optional build macro IR_REPEAT_EN: decode repeat frames, pulse ir_repeat
// and raise ir_irq on them; when undefined a repeat frame is an error.
module ir_nec_receiver
   import ir_nec_pkg::*;
#(
   parameter int TICK_DIV = 500,
   parameter int FILT_LEN = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ir_in,
   input  logic        irq_ack,
   output logic [15:0] ir_data,
   output logic        ir_valid,
   output logic        ir_repeat,
   output logic        ir_err,
   output logic        ir_irq,
   output logic        busy
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic             w_rise;
   logic             w_fall;
   logic             w_tick;
   logic [PRE_W-1:0] r_pre;
   logic [CNT_W-1:0] r_dur;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [31:0]      r_shift;
   logic [5:0]       r_bit_cnt;
   logic [15:0]      r_data;
   logic             r_valid;
   logic             r_err;
   logic             r_irq;

   logic             w_timeout;
   logic             w_shift_en;
   logic             w_bit_val;
   logic             w_cnt_clr;
   logic             w_load;
   logic             w_err_set;
   logic             w_irq_set;
`ifdef IR_REPEAT_EN
   logic             w_rpt_set;
   logic             r_rpt;
`endif

   ir_line_filter #(.FILT_LEN(FILT_LEN)) u_filter (
      .clk    (clk),
      .reset  (reset),
      .i_ir   (ir_in),
      .o_rise (w_rise),
      .o_fall (w_fall)
   );

   assign w_tick    = (r_pre == PRE_W'(TICK_DIV - 1));
   assign w_timeout = (r_dur == CNT_MAX);

   // Prescaler: one tick every TICK_DIV clocks
   always_ff @(posedge clk) begin
      if (reset || w_tick) r_pre <= '0;
      else                 r_pre <= r_pre + PRE_W'(1);
   end

   // Phase duration: cleared by every filtered edge, saturating tick count
   always_ff @(posedge clk) begin
      if (reset)                          r_dur <= '0;
      else if (w_rise || w_fall)          r_dur <= '0;
      else if (w_tick && !w_timeout)      r_dur <= r_dur + CNT_W'(1);
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state logic and datapath controls; windows are judged on the
   // edge that ends each phase, saturation of the counter is a timeout
   always_comb begin
      // NOTE: every signal gets a default here so no path leaves it unassigned (no latch).
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_bit_val   = 1'b0;
      w_cnt_clr   = 1'b0;
      w_load      = 1'b0;
      w_err_set   = 1'b0;
`ifdef IR_REPEAT_EN
      w_rpt_set   = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (w_fall) w_state_nxt = LEAD_MARK;
         end
         LEAD_MARK: begin
            if (w_rise) w_state_nxt = in_win(r_dur, LM_MIN, LM_MAX) ? LEAD_SPACE : ERR;
            else if (w_timeout) w_state_nxt = ERR;
         end
         LEAD_SPACE: begin
            if (w_fall) begin
               if (in_win(r_dur, LS_MIN, LS_MAX)) begin
                  w_state_nxt = BIT_MARK;
                  w_cnt_clr   = 1'b1;
               end
`ifdef IR_REPEAT_EN
               else if (in_win(r_dur, RS_MIN, RS_MAX)) w_state_nxt = RPT_MARK;
`endif
               else w_state_nxt = ERR;
            end else if (w_timeout) begin
               w_state_nxt = ERR;
            end
         end
         BIT_MARK: begin
            if (w_rise) w_state_nxt = in_win(r_dur, BM_MIN, BM_MAX) ? BIT_SPACE : ERR;
            else if (w_timeout) w_state_nxt = ERR;
         end
         BIT_SPACE: begin
            if (w_fall) begin
               if (in_win(r_dur, S0_MIN, S0_MAX) || in_win(r_dur, S1_MIN, S1_MAX)) begin
                  w_shift_en  = 1'b1;
                  w_bit_val   = in_win(r_dur, S1_MIN, S1_MAX);
                  w_state_nxt = (r_bit_cnt == 6'(FRAME_BITS - 1)) ? CHECK : BIT_MARK;
               end else begin
                  w_state_nxt = ERR;
               end
            end else if (w_timeout) begin
               w_state_nxt = ERR;
            end
         end
         CHECK: begin
            // byte1 is free for extended addressing; only cmd is verified
            if (r_shift[23:16] == ~r_shift[31:24]) begin
               w_load      = 1'b1;
               w_state_nxt = STOP;
            end else begin
               w_state_nxt = ERR;
            end
         end
         STOP: begin
            if (w_rise) w_state_nxt = IDLE;
            else if (w_timeout) w_state_nxt = ERR;
         end
         RPT_MARK: begin
            if (w_rise) begin
               if (in_win(r_dur, BM_MIN, BM_MAX)) begin
                  w_state_nxt = IDLE;
`ifdef IR_REPEAT_EN
                  w_rpt_set   = 1'b1;
`endif
               end else begin
                  w_state_nxt = ERR;
               end
            end else if (w_timeout) begin
               w_state_nxt = ERR;
            end
         end
         ERR: begin
            w_err_set   = 1'b1;
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

`ifdef IR_REPEAT_EN
   assign w_irq_set = w_load | w_rpt_set;
`else
   assign w_irq_set = w_load;
`endif

   // Frame assembly (LSB-first), result hand-off and output pulses
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_valid <= w_load;
         r_err   <= w_err_set;
         if (w_cnt_clr) begin
            r_bit_cnt <= '0;
         end else if (w_shift_en) begin
            r_bit_cnt <= r_bit_cnt + 6'd1;
            r_shift   <= {w_bit_val, r_shift[31:1]};
         end
         if (w_load) r_data <= {r_shift[7:0], r_shift[23:16]};
      end
   end

   // Sticky interrupt: a set event wins over a simultaneous acknowledge
   always_ff @(posedge clk) begin
      if (reset)          r_irq <= 1'b0;
      else if (w_irq_set) r_irq <= 1'b1;
      else if (irq_ack)   r_irq <= 1'b0;
   end

`ifdef IR_REPEAT_EN
   // Repeat-frame pulse
   always_ff @(posedge clk) begin
      if (reset) r_rpt <= 1'b0;
      else       r_rpt <= w_rpt_set;
   end
   assign ir_repeat = r_rpt;
`else
   assign ir_repeat = 1'b0;
`endif

   assign ir_data  = r_data;
   assign ir_valid = r_valid;
   assign ir_err   = r_err;
   assign ir_irq   = r_irq;
   assign busy     = (r_state != IDLE);

endmodule

// File: doc/ir_nec_receiver.md
Name: ir_nec_receiver

Overview:
- Decodes NEC-format infrared remote frames from the demodulated IR receiver pin.
- Presents a 16-bit {address, command} word that feeds the irdata PIO input port, plus a valid pulse and a sticky interrupt flag for the Nios II key-handling software.
- Sequences the IR capture path: line conditioning, pulse timing, frame assembly, integrity check, and result hand-off.

Parameters:
- TICK_DIV, 500, clk cycles per timing tick (10 us at 50 MHz).
- FILT_LEN, 4, consecutive equal samples needed to accept an ir_in level change.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ir_in  in  1  raw receiver output; active-low (mark = 0, idle = 1); asynchronous to clk.
- irq_ack  in  1  one-cycle pulse from software; clears ir_irq.
- ir_data  out  16  {addr_byte, cmd_byte} of the last good frame; connects to the PIO in_port.
- ir_valid  out  1  one-cycle pulse when ir_data updates.
- ir_repeat  out  1  one-cycle pulse on a valid repeat frame.
- ir_err  out  1  one-cycle pulse on a timing, timeout or checksum failure.
- ir_irq  out  1  sticky; set with ir_valid (and with ir_repeat when enabled).
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: every output is 0; FSM goes to IDLE; shift register, tick prescaler and duration counter are cleared. Reset mid-frame aborts the frame with no ir_err pulse.
- Conditioning:
  - 2-FF synchronizer, then a filter requiring FILT_LEN equal samples before the filtered level changes.
  - A glitch shorter than FILT_LEN cycles is invisible.
  - Edges are detected on the filtered level.
- Timing:
  - Prescaler produces a 1-cycle tick every TICK_DIV clks.
  - The 11-bit duration counter increments on each tick, saturates at 2047, and clears to 0 on every filtered edge.
- Window checks (ticks, inclusive) are evaluated on the edge that ends each phase:
  - Leader mark: 720..1080.
  - Leader space: 360..540.
  - Repeat space: 180..270.
  - Bit mark: 40..72.
  - Space "0": 40..72.
  - Space "1": 135..203.
- FSM states and transitions:
  - IDLE: falling edge -> LEAD_MARK.
  - LEAD_MARK: rising edge inside window -> LEAD_SPACE; outside -> ERR.
  - LEAD_SPACE: falling edge in leader-space window -> BIT_MARK with bit count 0. Falling edge in repeat-space window -> RPT_MARK. Otherwise -> ERR.
  - BIT_MARK: rising edge in bit-mark window -> BIT_SPACE; else -> ERR.
  - BIT_SPACE: on a falling edge, classify the space as 0/1 and shift it in LSB-first. If the count reaches 32 -> CHECK, else -> BIT_MARK. A space outside both windows -> ERR.
  - CHECK (1 cycle): accept if cmd == ~cmd_inv. Then ir_data = {byte0, byte2}, and ir_valid and ir_irq are set. Extended addressing is allowed, so byte1 is not checked. Next state STOP. On failure -> ERR with ir_data unchanged.
  - STOP: rising edge (end of stop mark) -> IDLE. Mark width is not checked.
  - RPT_MARK: rising edge in bit-mark window -> IDLE and pulse ir_repeat; else -> ERR.
  - ERR (1 cycle): pulse ir_err, then -> IDLE.
- Timeout: counter saturation in any state other than IDLE -> ERR.
- Latency: ir_valid is asserted 2 clks after the filtered falling edge that ends bit 31's space.
- Outputs:
  - ir_data holds its value until the next accepted frame.
  - ir_irq stays set until irq_ack. If irq_ack and a set event occur in the same cycle, set wins.
- An edge while in ERR or CHECK is ignored; the counter still clears on it.

Optional Feature:
- IR_REPEAT_EN defined:
  - The repeat-space window is decoded and ir_repeat pulses as described.
  - ir_irq is also set on a repeat, so held keys auto-repeat in software.
- IR_REPEAT_EN undefined:
  - A leader space in the repeat window is treated as an out-of-window space -> ERR.
  - ir_repeat is tied to 0.

Decomposition:
- Package ir_nec_pkg holds:
  - The state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, CHECK, STOP, RPT_MARK, ERR).
  - All window min/max tick constants.
  - Counter width 11 and frame length 32.
- Sub-module ir_line_filter: synchronizer, FILT_LEN filter, and rise/fall edge pulses. Parameter FILT_LEN.

Test Plan:
- Valid frame, addr 0x00, inv 0xFF, cmd 0x45, inv 0xBA -> ir_data=0x0045, one ir_valid pulse, ir_irq=1; irq_ack then clears ir_irq.
- Same frame with last byte 0xBB -> ir_err pulse, ir_data keeps its previous value, no ir_valid, ir_irq unchanged.
- Valid frame then 9 ms mark + 2.25 ms space + 560 us mark -> ir_repeat pulse and ir_irq set with IR_REPEAT_EN defined; with it undefined -> ir_err only.
- 2-cycle low glitches injected every 100 us during a valid frame (cmd 0x16) -> ir_data=0x0016, no ir_err.
- Line held low 25 ms after the leader -> ir_err when the counter saturates, busy drops; a following frame (cmd 0x0C) decodes to 0x000C.
- reset pulsed after bit 15 -> all outputs 0 with no ir_err; the next full frame decodes correctly.
